dds_hop_ctrl: RTL and testbench

Frequency-hop scheduler for the DDS core. Holds a small table of (step, cnt, dwell) entries and drives the DDS step/cnt/clr inputs entry by entry. Each entry is held for a programmed number of clocks. Supports one-shot or looping sweeps, start/stop control, and table writes while running.

---
 rtl/dds_hop_ctrl.sv | 150 +++++++++++++++
 tb/tb_dds_hop_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_hop_ctrl.sv
// Frequency-hop scheduler: plays (step, cnt, dwell) entries from a small table
// into the DDS step/cnt/clr inputs, one entry per hop, one-shot or looping.
module dds_hop_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [39:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [AW:0]   num_hops,
  output logic [7:0]    dds_step,
  output logic [15:0]   dds_cnt,
  output logic          dds_clr,
  output logic          busy,
  output logic [AW-1:0] hop_idx,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] idx_s;
  logic [AW:0]   idx_inc_s;
  logic [AW:0]   hops_r;
  logic [AW:0]   hops_clamp_s;
  logic [15:0]   dwell_r;
  logic [15:0]   dwell_load_s;
  logic [39:0]   mem_r [DEPTH];
  logic [39:0]   rd_data_r;
  logic          abort_s;

  assign idx_inc_s    = {1'b0, idx_r} + {{AW{1'b0}}, 1'b1};
  assign hops_clamp_s = (num_hops > DEPTH_W) ? DEPTH_W : num_hops;
  assign dwell_load_s = (rd_data_r[15:0] == 16'd0) ? 16'd0 : (rd_data_r[15:0] - 16'd1);
  assign abort_s      = stop && (state_r != S_IDLE);

  // Next state and next table index; stop overrides every non-idle transition.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (start && !stop && (num_hops != {(AW+1){1'b0}})) begin
          state_s = S_LOAD;
          idx_s   = {AW{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: state_s = S_RUN;
      S_RUN: begin
        if (dwell_r != 16'd0) begin
          state_s = S_RUN;
        end else if (idx_inc_s < hops_r) begin
          state_s = S_LOAD;
          idx_s   = idx_inc_s[AW-1:0];
        end else if (loop_en) begin
          state_s = S_LOAD;
          idx_s   = {AW{1'b0}};
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    if (abort_s) begin
      state_s = S_IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Hop table: the read is addressed by the next index, so the entry is
  // captured on the edge that enters LOAD; a same-edge write yields old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data_r <= mem_r[idx_s];
  end

  // Sequencer state and registered DDS-facing outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      idx_r    <= {AW{1'b0}};
      hops_r   <= {(AW+1){1'b0}};
      dwell_r  <= 16'd0;
      dds_step <= 8'd0;
      dds_cnt  <= 16'd0;
      dds_clr  <= 1'b0;
      busy     <= 1'b0;
      hop_idx  <= {AW{1'b0}};
      done     <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      busy    <= (state_s != S_IDLE);
      dds_clr <= 1'b0;
      done    <= 1'b0;
      if (abort_s) begin
        dds_step <= 8'd0;
        dds_cnt  <= 16'd0;
        dds_clr  <= 1'b1;
      end else begin
        case (state_r)
          S_IDLE: begin
            dds_step <= 8'd0;
            if (state_s == S_LOAD) begin
              hops_r <= hops_clamp_s;
            end
          end
          S_LOAD: begin
            dds_step <= rd_data_r[39:32];
            dds_cnt  <= rd_data_r[31:16];
            hop_idx  <= idx_r;
            dds_clr  <= 1'b1;
            dwell_r  <= dwell_load_s;
          end
          S_RUN: begin
            if (dwell_r != 16'd0) begin
              dwell_r <= dwell_r - 16'd1;
            end
          end
          S_DONE: begin
            done     <= 1'b1;
            dds_step <= 8'd0;
          end
          default: begin
            dds_step <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_hop_ctrl.sv
// Scoreboard bench for dds_hop_ctrl: a timeline reference model predicts hop,
// done and stop events plus steady output values; a monitor checks the DUT.
module tb_dds_hop_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [39:0] wr_data;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [4:0]  num_hops;
  logic [7:0]  dds_step;
  logic [15:0] dds_cnt;
  logic        dds_clr;
  logic        busy;
  logic [3:0]  hop_idx;
  logic        done;

  dds_hop_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .num_hops(num_hops),
    .dds_step(dds_step), .dds_cnt(dds_cnt), .dds_clr(dds_clr), .busy(busy),
    .hop_idx(hop_idx), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          t;
    logic        clr;
    logic        dn;
    logic [7:0]  step;
    logic [15:0] cnt;
    logic [3:0]  idx;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  logic [39:0] m_tab [16];
  bit          m_run = 1'b0;
  int          m_hops, m_idx, t_read, t_out, t_dec, t_done;
  logic [39:0] m_snap;
  logic [7:0]  m_step = 8'd0;
  logic [15:0] m_cnt = 16'd0;
  logic [3:0]  m_cur = 4'd0;
  bit          m_busy = 1'b0;

  function automatic ev_t mk_ev(input int t, input logic clr, input logic dn,
                                input logic [7:0] s, input logic [15:0] c, input logic [3:0] i);
    ev_t e;
    e.t = t; e.clr = clr; e.dn = dn; e.step = s; e.cnt = c; e.idx = i;
    return e;
  endfunction

  // Reference model: schedules each hop by absolute edge number from dwell arithmetic.
  initial begin : ref_model
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_run = 1'b0; m_step = 8'd0; m_cnt = 16'd0; m_cur = 4'd0;
        t_read = -1; t_out = -1; t_dec = -1; t_done = -1;
      end else if (m_run && stop) begin
        m_step = 8'd0; m_cnt = 16'd0; m_run = 1'b0;
        exp_q.push_back(mk_ev(cyc, 1'b1, 1'b0, 8'd0, 16'd0, m_cur));
      end else if (m_run) begin
        if (cyc == t_dec) begin
          if (m_idx < m_hops - 1) begin m_idx++; t_read = cyc; end
          else if (loop_en) begin m_idx = 0; t_read = cyc; end
          else t_done = cyc + 1;
        end
        if (cyc == t_read) begin m_snap = m_tab[m_idx]; t_out = cyc + 1; end
        if (cyc == t_out) begin
          m_step = m_snap[39:32]; m_cnt = m_snap[31:16]; m_cur = 4'(m_idx);
          t_dec = cyc + ((m_snap[15:0] == 16'd0) ? 1 : int'(m_snap[15:0]));
          exp_q.push_back(mk_ev(cyc, 1'b1, 1'b0, m_step, m_cnt, m_cur));
        end
        if (cyc == t_done) begin
          m_step = 8'd0; m_run = 1'b0;
          exp_q.push_back(mk_ev(cyc, 1'b0, 1'b1, 8'd0, m_cnt, m_cur));
        end
      end else if (start && !stop && num_hops != 5'd0) begin
        m_run = 1'b1; m_idx = 0;
        m_hops = (num_hops > 5'd16) ? 16 : int'(num_hops);
        m_snap = m_tab[0]; t_out = cyc + 1; t_dec = -1; t_done = -1;
      end
      m_busy = m_run;
      if (rst && wr_en) m_tab[wr_addr] = wr_data;
      cyc++;
    end
  end

  // Monitor: steady outputs every cycle, plus one scoreboard pop per predicted event.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        n_cmp++;
        if ({busy, dds_step, dds_cnt, hop_idx} !== {m_busy, m_step, m_cnt, m_cur}) begin
          n_fail++;
          $display("FAIL state cyc=%0d: got busy=%0b step=%0d cnt=%0d idx=%0d, expected busy=%0b step=%0d cnt=%0d idx=%0d",
                   cyc, busy, dds_step, dds_cnt, hop_idx, m_busy, m_step, m_cnt, m_cur);
        end
        if (exp_q.size() != 0 && exp_q[0].t == cyc - 1) begin
          e = exp_q.pop_front();
          n_cmp++;
          if ({dds_clr, done, dds_step, dds_cnt, hop_idx} !== {e.clr, e.dn, e.step, e.cnt, e.idx}) begin
            n_fail++;
            $display("FAIL event cyc=%0d: got clr=%0b done=%0b step=%0d cnt=%0d idx=%0d, expected clr=%0b done=%0b step=%0d cnt=%0d idx=%0d",
                     cyc, dds_clr, done, dds_step, dds_cnt, hop_idx, e.clr, e.dn, e.step, e.cnt, e.idx);
          end
        end else if (dds_clr !== 1'b0 || done !== 1'b0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_event cyc=%0d: got clr=%0b done=%0b, expected clr=0 done=0", cyc, dds_clr, done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] s, input logic [15:0] c, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = {s, c, d};
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] n);
    num_hops = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1; tick(); stop = 1'b0; tick();
  endtask

  task automatic wait_hop(input logic [3:0] idx, input int budget, input string nm, output int n);
    bit found;
    found = 1'b0; n = 0;
    while (!found && n < budget) begin
      tick(); n++;
      if (dds_clr === 1'b1 && busy === 1'b1 && hop_idx === idx) found = 1'b1;
    end
    chk(nm, 64'(found), 64'd1);
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (done === 1'b1) found = 1'b1;
    end
    chk(nm, 64'(found), 64'd1);
  endtask

  initial begin : main
    int n, hops, mx;
    bit fin;
    rst = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 40'd0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; num_hops = 5'd0;
    tick(); mon_on = 1'b1;
    tick(); tick();
    rst = 1'b1;
    chk("rst_outputs", {dds_step, dds_cnt, dds_clr, busy, hop_idx, done}, 64'd0);
    for (int i = 0; i < 16; i++) wr(4'(i), 8'($urandom), 16'($urandom), 16'($urandom_range(0, 3)));
    pulse_start(5'd0); tick();
    chk("start_zero_hops_busy", 64'(busy), 64'd0);

    // One-shot, two entries
    wr(4'd0, 8'd5, 16'd0, 16'd4);
    wr(4'd1, 8'd10, 16'd3, 16'd2);
    loop_en = 1'b0;
    pulse_start(5'd2);
    tick();
    chk("t2_hop0", {dds_step, dds_clr, hop_idx}, {51'd0, 8'd5, 1'b1, 4'd0});
    repeat (5) tick();
    chk("t7_hop1", {dds_step, dds_cnt, dds_clr, hop_idx}, {35'd0, 8'd10, 16'd3, 1'b1, 4'd1});
    repeat (3) tick();
    chk("t10_done", 64'(done), 64'd1);
    tick();
    chk("t11_idle", {busy, dds_step}, 64'd0);

    // Looping with a zero-dwell entry, then drop loop_en during entry 2
    wr(4'd0, 8'd7, 16'd1, 16'd3);
    wr(4'd1, 8'd8, 16'd2, 16'd0);
    wr(4'd2, 8'd9, 16'd4, 16'd2);
    loop_en = 1'b1;
    pulse_start(5'd3);
    wait_hop(4'd0, 5, "loop_h0", n);
    wait_hop(4'd1, 10, "loop_h1", n);
    chk("entry0_period", 64'(n), 64'd4);
    wait_hop(4'd2, 10, "loop_h2", n);
    chk("dwell0_period", 64'(n), 64'd2);
    wait_hop(4'd0, 10, "loop_wrap", n);
    chk("entry2_period", 64'(n), 64'd3);
    wait_hop(4'd1, 10, "loop_h1b", n);
    wait_hop(4'd2, 10, "loop_h2b", n);
    loop_en = 1'b0;
    wait_done(10, "loop_exit_done");
    tick();

    // Stop mid-run, then start+stop together from idle
    loop_en = 1'b1;
    pulse_start(5'd3);
    wait_hop(4'd1, 20, "stop_h1", n);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_outputs", {dds_step, dds_cnt, dds_clr, done, busy}, 64'd4);
    start = 1'b1; stop = 1'b1; num_hops = 5'd3; tick();
    start = 1'b0; stop = 1'b0; tick();
    chk("start_stop_idle", 64'(busy), 64'd0);

    // Writes while running, including one on the edge that reads the entry
    wr(4'd0, 8'd1, 16'd5, 16'd6);
    wr(4'd1, 8'd2, 16'd6, 16'd2);
    loop_en = 1'b1;
    pulse_start(5'd2);
    wait_hop(4'd0, 5, "wr_h0", n);
    wr(4'd1, 8'd20, 16'd6, 16'd2);
    wait_hop(4'd1, 10, "wr_h1", n);
    chk("wr_run_step", 64'(dds_step), 64'd20);
    wait_hop(4'd0, 10, "wr_h0b", n);
    repeat (5) tick();
    wr(4'd1, 8'd33, 16'd6, 16'd2);
    wait_hop(4'd1, 3, "wr_h1b", n);
    chk("wr_load_old", 64'(dds_step), 64'd20);
    wait_hop(4'd0, 10, "wr_h0c", n);
    wait_hop(4'd1, 10, "wr_h1c", n);
    chk("wr_load_new", 64'(dds_step), 64'd33);
    halt();

    // num_hops above DEPTH clamps to DEPTH
    for (int i = 0; i < 16; i++) wr(4'(i), 8'($urandom), 16'($urandom), 16'($urandom_range(0, 3)));
    loop_en = 1'b0;
    pulse_start(5'd17);
    hops = 0; mx = 0; fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      tick();
      if (dds_clr === 1'b1 && busy === 1'b1) begin
        hops++;
        if (int'(hop_idx) > mx) mx = int'(hop_idx);
      end
      if (done === 1'b1) fin = 1'b1;
    end
    chk("clamp_done", 64'(fin), 64'd1);
    chk("clamp_hops", 64'(hops), 64'd16);
    chk("clamp_max_idx", 64'(mx), 64'd15);
    tick();

    // Randomized control traffic
    for (int r = 0; r < 6; r++) begin
      loop_en = 1'($urandom_range(0, 1));
      pulse_start(5'($urandom_range(0, 17)));
      for (int c = 0; c < 120; c++) begin
        start    = ($urandom_range(0, 19) == 0);
        stop     = ($urandom_range(0, 39) == 0);
        num_hops = 5'($urandom_range(0, 17));
        if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
        wr_en    = ($urandom_range(0, 5) == 0);
        wr_addr  = 4'($urandom_range(0, 15));
        wr_data  = {8'($urandom), 16'($urandom), 16'($urandom_range(0, 4))};
        tick();
      end
      start = 1'b0; wr_en = 1'b0;
      halt();
    end

    repeat (3) tick();
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
